ifu_fetch: RTL

Instruction fetch unit for the single-issue NPC core. Holds the architectural PC and fetches one 32-bit instruction at a time over a valid/ready memory request/response port. It presents each fetched instruction, with its PC, to the decode stage through a valid/ready handshake, and it accepts PC redirects from jump/branch resolution. It sits directly upstream of the decoder and drives the decoder's `inst` input and its write-enable qualifier.

---
 rtl/ifu_fetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit for the single-issue NPC core. Holds the
// architectural PC, fetches one 32-bit instruction at a time over a
// valid/ready memory port, and hands each instruction (with its PC) to the
// decoder through a valid/ready handshake. Jump/branch resolution can
// redirect the PC at any time except after a fault.
//
// Ports:
//   clk, rst        : single clock; synchronous active-high reset
//   imem_req_valid  : out, fetch request valid (REQ state)
//   imem_req_ready  : in,  memory accepts the request
//   imem_addr       : out, fetch address (always equal to pc)
//   imem_rsp_valid  : in,  response valid (no response back-pressure)
//   imem_rsp_data   : in,  instruction word
//   imem_rsp_err    : in,  access fault, qualified by imem_rsp_valid
//   inst_valid      : out, inst/pc valid for decode (decoder write enable)
//   inst_ready      : in,  decoder consumes the instruction
//   inst            : out, registered instruction word
//   pc              : out, PC of the current or outstanding fetch
//   redirect_valid  : in,  replace the PC (jump / taken branch)
//   redirect_pc     : in,  new PC
//   fetch_fault     : out, sticky fault; unit halted until rst
//
// Build option:
//   IFU_ALIGN_CHECK_EN - when defined, a PC with bits [1:0] != 0 is never
//   sent to memory; the unit moves to FAULT instead.
//
// All outputs are decoded from registered state only, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_s;
   logic [31:0] inst_r;
   logic [31:0] inst_s;
   // Set when the outstanding response belongs to a PC that was redirected away.
   logic        drop_r;
   logic        drop_s;
   logic        misaligned_s;

`ifdef IFU_ALIGN_CHECK_EN
   assign misaligned_s = (pc_r[1:0] != 2'b00);
`else
   assign misaligned_s = 1'b0;
`endif

   // Outputs decoded purely from registered state.
   assign imem_req_valid = (state_r == ST_REQ) && !misaligned_s;
   assign imem_addr      = pc_r;
   assign pc             = pc_r;
   assign inst           = inst_r;
   assign inst_valid     = (state_r == ST_HOLD);
   assign fetch_fault    = (state_r == ST_FAULT);

   // Next-state, next-PC, instruction latch and drop-flag logic.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      inst_s  = inst_r;
      drop_s  = drop_r;
      case (state_r)
         ST_REQ: begin
            if (misaligned_s) begin
               // No request is ever issued for a misaligned PC.
               state_s = ST_FAULT;
            end else begin
               if (redirect_valid) begin
                  pc_s = redirect_pc;
               end else begin
                  pc_s = pc_r;
               end
               if (imem_req_ready) begin
                  // A redirect in the accept cycle makes this request stale.
                  state_s = ST_WAIT;
                  drop_s  = redirect_valid;
               end else begin
                  state_s = ST_REQ;
                  drop_s  = 1'b0;
               end
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_s = redirect_pc;
               if (imem_rsp_valid) begin
                  // Response in the redirect cycle is stale; refetch now.
                  state_s = ST_REQ;
                  drop_s  = 1'b0;
               end else begin
                  state_s = ST_WAIT;
                  drop_s  = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (drop_r) begin
                  // Stale response (data or error) is discarded.
                  state_s = ST_REQ;
                  drop_s  = 1'b0;
               end else if (imem_rsp_err) begin
                  state_s = ST_FAULT;
               end else begin
                  inst_s  = imem_rsp_data;
                  state_s = ST_HOLD;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               // Redirect wins over pc+4; a same-cycle inst_ready still
               // counts as a transfer since inst_valid is high.
               pc_s    = redirect_pc;
               state_s = ST_REQ;
            end else if (inst_ready) begin
               pc_s    = pc_r + 32'd4;
               state_s = ST_REQ;
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_FAULT: begin
            state_s = ST_FAULT;
         end
         default: begin
            state_s = ST_FAULT;
         end
      endcase
   end

   // State, PC, instruction and drop-flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_PC;
         inst_r  <= NOP_INST;
         drop_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         inst_r  <= inst_s;
         drop_r  <= drop_s;
      end
   end

endmodule
